// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_op_sequencer
// Brief   : Initiator for a combinational 8-bit ALU. Takes one command at a
//           time over a valid/ready port, holds the operands on the ALU for a
//           fixed settle time, captures result and qualified carry, and returns
//           them over a valid/ready response port. Counts completed responses
//           with a saturating counter.
// Revision: 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic [1:0]           cmd_op,
  output logic [WIDTH-1:0]     alu_op_a,
  output logic [WIDTH-1:0]     alu_op_b,
  output logic [1:0]           alu_op_code,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_carry,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 res_carry,
  output logic [1:0]           res_op,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_count
);

  // Settle counter only needs to reach SETTLE_CYCLES-1.
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] C_SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SCW-1:0]       settle_q, settle_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [1:0]           alu_code_q, alu_code_d;
  logic [WIDTH-1:0]     res_data_q, res_data_d;
  logic                 res_carry_q, res_carry_d;
  logic [1:0]           res_op_q, res_op_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_code_q  <= 2'b00;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_op_q    <= 2'b00;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_code_q  <= alu_code_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_op_q    <= res_op_d;
      op_count_q  <= op_count_d;
    end
  end

  // Next-state and datapath updates for the IDLE -> DRIVE -> RESP loop.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_code_d  = alu_code_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_op_d    = res_op_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Operand B is registered even for TWO; the ALU just ignores it.
          alu_a_d    = cmd_a;
          alu_b_d    = cmd_b;
          alu_code_d = cmd_op;
          settle_d   = '0;
          state_d    = S_DRIVE;
        end
      end
      S_DRIVE: begin
        settle_d = settle_q + SCW'(1);
        if (settle_q == C_SETTLE_LAST) begin
          res_data_d  = alu_out;
          res_op_d    = alu_code_q;
          // Only ADD (00) and TWO (10) carry meaning; SUB/XOR report none.
          res_carry_d = alu_carry & ~alu_code_q[0];
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          if (op_count_q != C_CNT_MAX) begin
            op_count_d = op_count_q + CNT_WIDTH'(1);
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign alu_op_a    = alu_a_q;
  assign alu_op_b    = alu_b_q;
  assign alu_op_code = alu_code_q;
  assign res_data    = res_data_q;
  assign res_carry   = res_carry_q;
  assign res_op      = res_op_q;
  assign op_count    = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_op_sequencer
// Brief   : Self-checking bench. Instance 0 uses SETTLE_CYCLES=1/CNT_WIDTH=16,
//           instance 1 uses SETTLE_CYCLES=3/CNT_WIDTH=2. Both drive a bench
//           ALU; results are compared against an arithmetic reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n     [2];
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [7:0] cmd_a     [2];
  logic [7:0] cmd_b     [2];
  logic [1:0] cmd_op    [2];
  logic [7:0] alu_a     [2];
  logic [7:0] alu_b     [2];
  logic [1:0] alu_code  [2];
  logic [8:0] alu_res   [2];
  logic [7:0] alu_out   [2];
  logic       alu_carry [2];
  logic       force_c   [2];
  logic       res_valid [2];
  logic       res_ready [2];
  logic [7:0] res_data  [2];
  logic       res_carry [2];
  logic [1:0] res_op    [2];
  logic       busy      [2];
  logic [15:0] op_cnt1;
  logic [1:0]  op_cnt3;

  int total = 0;
  int bad   = 0;
  int exp_cnt [2];

  always #5 clk = ~clk;

  // Bench ALU: add/sub/negate/xor with carry (borrow for SUB), carry pin forceable.
  function automatic logic [8:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, ~a} + 9'd1;
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign alu_res[0]   = alu_f(alu_code[0], alu_a[0], alu_b[0]);
  assign alu_res[1]   = alu_f(alu_code[1], alu_a[1], alu_b[1]);
  assign alu_out[0]   = alu_res[0][7:0];
  assign alu_out[1]   = alu_res[1][7:0];
  assign alu_carry[0] = alu_res[0][8] | force_c[0];
  assign alu_carry[1] = alu_res[1][8] | force_c[1];

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]),
    .alu_op_a(alu_a[0]), .alu_op_b(alu_b[0]), .alu_op_code(alu_code[0]),
    .alu_out(alu_out[0]), .alu_carry(alu_carry[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
    .res_carry(res_carry[0]), .res_op(res_op[0]), .busy(busy[0]), .op_count(op_cnt1)
  );

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3), .CNT_WIDTH(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]),
    .alu_op_a(alu_a[1]), .alu_op_b(alu_b[1]), .alu_op_code(alu_code[1]),
    .alu_out(alu_out[1]), .alu_carry(alu_carry[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
    .res_carry(res_carry[1]), .res_op(res_op[1]), .busy(busy[1]), .op_count(op_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result {carry, data} from the operation definitions.
  function automatic logic [8:0] ref_res(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int s;
    case (op)
      2'b00: begin s = int'(a) + int'(b); return {s > 255, 8'(s % 256)}; end
      2'b01: begin s = (int'(a) - int'(b) + 256) % 256; return {1'b0, 8'(s)}; end
      2'b10: begin s = (256 - int'(a)) % 256; return {a == 8'd0, 8'(s)}; end
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  function automatic logic [15:0] get_cnt(input int k);
    return (k == 0) ? op_cnt1 : {14'd0, op_cnt3};
  endfunction

  // One full transaction; starts and ends just after a falling edge.
  task automatic run_op(input int k, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic fc, input int hold);
    int         n;
    int         settle;
    int         cmax;
    logic [8:0] e;
    settle = (k == 0) ? 1 : 3;
    cmax   = (k == 0) ? 65535 : 3;
    e      = ref_res(op, a, b);
    force_c[k]   = fc;
    cmd_a[k]     = a;
    cmd_b[k]     = b;
    cmd_op[k]    = op;
    cmd_valid[k] = 1'b1;
    check("cmd_ready_idle", 32'(cmd_ready[k]), 32'd1);
    @(posedge clk); @(negedge clk);
    cmd_valid[k] = 1'b0;
    check("busy", 32'(busy[k]), 32'd1);
    check("alu_op_a", 32'(alu_a[k]), 32'(a));
    check("alu_op_code", 32'(alu_code[k]), 32'(op));
    n = 0;
    while (!res_valid[k] && n < 40) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("latency", 32'(n), 32'(settle));
    check("res_data", 32'(res_data[k]), 32'(e[7:0]));
    check("res_carry", 32'(res_carry[k]), 32'(e[8]));
    check("res_op", 32'(res_op[k]), 32'(op));
    for (int i = 0; i < hold; i++) begin
      cmd_valid[k] = 1'($urandom_range(0, 1));
      cmd_a[k]     = 8'($urandom);
      @(posedge clk); @(negedge clk);
      check("bp_res_valid", 32'(res_valid[k]), 32'd1);
      check("bp_res_data", 32'(res_data[k]), 32'(e[7:0]));
      check("bp_cmd_ready", 32'(cmd_ready[k]), 32'd0);
      check("bp_op_count", 32'(get_cnt(k)), 32'(exp_cnt[k]));
      check("bp_alu_op_a", 32'(alu_a[k]), 32'(a));
    end
    // Command offered during the handshake cycle must be ignored.
    cmd_valid[k] = 1'b1;
    cmd_a[k]     = ~a;
    res_ready[k] = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready[k] = 1'b0;
    cmd_valid[k] = 1'b0;
    force_c[k]   = 1'b0;
    if (exp_cnt[k] < cmax) exp_cnt[k]++;
    check("post_res_valid", 32'(res_valid[k]), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready[k]), 32'd1);
    check("op_count", 32'(get_cnt(k)), 32'(exp_cnt[k]));
    check("hs_no_accept", 32'(alu_a[k]), 32'(a));
  endtask

  task automatic check_reset(input int k);
    check("rst_cmd_ready", 32'(cmd_ready[k]), 32'd1);
    check("rst_res_valid", 32'(res_valid[k]), 32'd0);
    check("rst_busy", 32'(busy[k]), 32'd0);
    check("rst_alu_a", 32'(alu_a[k]), 32'd0);
    check("rst_alu_b", 32'(alu_b[k]), 32'd0);
    check("rst_alu_code", 32'(alu_code[k]), 32'd0);
    check("rst_res_data", 32'(res_data[k]), 32'd0);
    check("rst_res_carry", 32'(res_carry[k]), 32'd0);
    check("rst_res_op", 32'(res_op[k]), 32'd0);
    check("rst_op_count", 32'(get_cnt(k)), 32'd0);
  endtask

  task automatic rand_op(input int k);
    logic [1:0] op;
    logic       fc;
    op = 2'($urandom_range(0, 3));
    fc = op[0] ? 1'($urandom_range(0, 1)) : 1'b0;
    run_op(k, op, 8'($urandom), 8'($urandom), fc, $urandom_range(0, 3));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; cmd_valid[k] = 1'b0; cmd_a[k] = '0; cmd_b[k] = '0;
      cmd_op[k] = '0; res_ready[k] = 1'b0; force_c[k] = 1'b0; exp_cnt[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    check_reset(0);
    check_reset(1);

    // Directed cases on the single-settle instance.
    run_op(0, 2'b00, 8'hFF, 8'h01, 1'b0, 0);
    run_op(0, 2'b01, 8'h05, 8'h07, 1'b1, 0);
    run_op(0, 2'b10, 8'h00, 8'h5A, 1'b0, 0);
    run_op(0, 2'b10, 8'h01, 8'h33, 1'b0, 0);
    run_op(0, 2'b11, 8'h3C, 8'hF0, 1'b1, 5);
    for (int i = 0; i < 25; i++) rand_op(0);

    // Three-cycle settle, 2-bit counter: back-to-back ops saturate at 3.
    for (int i = 0; i < 5; i++) run_op(1, 2'b00, 8'($urandom), 8'($urandom), 1'b0, 0);

    // Reset while in DRIVE discards the op and clears the counter.
    cmd_a[1] = 8'h12; cmd_b[1] = 8'h34; cmd_op[1] = 2'b00; cmd_valid[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid[1] = 1'b0;
    check("drive_busy", 32'(busy[1]), 32'd1);
    rst_n[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n[1] = 1'b1;
    exp_cnt[1] = 0;
    check_reset(1);
    repeat (4) begin
      @(posedge clk); @(negedge clk);
    end
    check("rst_no_resp", 32'(res_valid[1]), 32'd0);
    run_op(1, 2'b11, 8'hA5, 8'h0F, 1'b0, 0);
    check("xor_value", 32'(res_data[1]), 32'hAA);
    for (int i = 0; i < 8; i++) rand_op(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
